screen_mem_arbiter: RTL and testbench
=====================================

# screen_mem_arbiter

Single-port arbiter and sequencer for the screen memory. It shares one synchronous-read screen RAM between the VGA scan-out fetch, a CPU load/store port and a built-in clear engine. Priority is strict: VGA first, then clear, then CPU. The block sits between `VGA320x240_Controller` / the CPU memory map and the `RAMROM`-style screen store, and owns every access to that store.

## Interface
- `ADDR_W`, 16: word address width on all ports.
- `DATA_W`, 16: data word width.
- `DEPTH`, 4800: valid screen words (320×240 / 16); addresses ≥ DEPTH are out of range.
- `CLEAR_VAL`, 16'h0000: word written by the clear engine.

Ports:
- `clk` in 1: system clock (100 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `vga_req` in 1: VGA fetch request, single-cycle pulse.
- `vga_addr` in ADDR_W: VGA fetch address.
- `vga_data` out DATA_W: fetched word; held until the next VGA fetch returns.
- `vga_valid` out 1: one-cycle pulse when `vga_data` updates.
- `cpu_req` in 1: CPU request valid; held until accepted.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_ready` out 1: CPU request accepted this cycle.
- `cpu_rdata` out DATA_W: CPU read data.
- `cpu_rvalid` out 1: one-cycle pulse when `cpu_rdata` is valid.
- `cpu_err` out 1: one-cycle pulse when an out-of-range CPU access is accepted.
- `clear_start` in 1: start-clear pulse.
- `clear_busy` out 1: clear in progress.
- `clear_done` out 1: one-cycle pulse after the last clear write.
- `ram_en` out 1: RAM access enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data, valid the cycle after the address.

## Operation
- **One RAM slot per cycle.** The grant is combinational from the current-cycle requests: `vga_req` wins, then CLEAR state, then `cpu_req`.
- **VGA.**
  - In range: `ram_en`=1, `ram_we`=0.
  - Out of range: no RAM access; the return word is 0.
  - A return is always produced: `vga_valid` pulses.
- **CPU.**
  - `cpu_ready` = `cpu_req` & !`vga_req` & state==IDLE.
  - Write: the RAM write occurs in the acceptance cycle, and nothing is returned.
  - Read: `cpu_rvalid` pulses with the data.
  - Out of range: accepted normally, with no RAM access. Reads return 0 with `cpu_rvalid`. `cpu_err` pulses in the acceptance cycle.
- **Clear FSM** (states IDLE, CLEAR).
  - IDLE→CLEAR on `clear_start`. The counter loads 0 and `clear_busy`=1 from the next cycle.
  - In CLEAR, every cycle without `vga_req` writes `CLEAR_VAL` to the counter address, then increments the counter.
  - After writing DEPTH−1, the FSM goes CLEAR→IDLE and `clear_done` pulses in the first IDLE cycle.
  - `clear_start` during CLEAR is ignored.
  - `cpu_ready` stays 0 throughout CLEAR.
- **Return routing.** An owner tag (NONE/VGA/CPU), plus an out-of-range flag, is registered alongside each RAM issue. The tag routes `ram_rdata` to the correct port.
- **Reset** (asynchronous):
  - All outputs 0; `vga_data`, `cpu_rdata` = 0.
  - FSM = IDLE, counter = 0, tag = NONE.
  - Reset mid-clear leaves memory partially cleared. That is acceptable.
  - In-flight returns are discarded.

## Timing
- Requests are sampled in cycle N, and RAM latches the address at the end of N.
- `ram_rdata` is valid in N+1 and registered at the end of N+1.
- `vga_data`/`vga_valid` and `cpu_rdata`/`cpu_rvalid` appear in cycle N+2. Read latency is fixed at 2 for both ports, including out-of-range returns.
- Back-to-back requests every cycle are supported, giving one return per cycle in order.
- A CPU request blocked by `vga_req` waits; `cpu_req`/`cpu_addr`/`cpu_we`/`cpu_wdata` must stay stable until `cpu_ready`.
- The VGA controller fetches at most once per 128 clk, so CPU waits are at most 1 cycle outside CLEAR.
- Clear duration is DEPTH cycles plus the number of VGA-stolen cycles.
- `vga_req` and `clear_start` in the same cycle: the VGA read is served and CLEAR entry still happens.

## Structure
- Package `screen_arb_pkg`:
  - state enum {IDLE, CLEAR};
  - owner enum {OWN_NONE, OWN_VGA, OWN_CPU};
  - default `DEPTH`/`CLEAR_VAL` constants.
- Sub-module `screen_clear_engine`: holds the counter, FSM, `clear_busy`/`clear_done`, and a `slot_free` input/`wr_fire` handshake.
- Grant mux, tag pipeline and return routing live in the top.

## Test plan
- **Basic returns.** CPU write addr 5 = 16'hA5A5, then CPU read addr 5 → `cpu_rvalid` 2 cycles after `cpu_ready`, with `cpu_rdata`=16'hA5A5. A VGA read of addr 5 → `vga_data`=16'hA5A5, 2 cycles after `vga_req`.
- **VGA priority collision.** `vga_req`(addr 7) and `cpu_req` read (addr 9) in the same cycle → `cpu_ready`=0 that cycle and 1 the next. Returns in order: VGA with mem[7], then CPU with mem[9] one cycle later.
- **Clear with stolen slots.** `clear_start` with `vga_req` every 10th cycle → all 4800 words = 16'h0000 after. `clear_done` pulses exactly once. `cpu_ready`=0 throughout `clear_busy`. The stolen VGA reads return correctly.
- **Out-of-range CPU.** CPU write to 4800 → `cpu_err` pulse, `ram_en`=0. CPU read of 16'hFFFF → `cpu_rdata`=0, `cpu_rvalid` at +2, `cpu_err` pulse.
- **Reset mid-clear.** Assert `reset` at clear count 2000 → all outputs 0 immediately. A new `clear_start` restarts from addr 0 and completes in 4800 cycles without VGA traffic.
- **Ignored restart.** Back-to-back CPU reads every cycle for 20 cycles, then `clear_start` during CLEAR → in-order `cpu_rvalid` stream with no gaps. The second `clear_start` has no effect on duration.

Source files
------------

// File: rtl/screen_arb_pkg.sv
// Shared types and default constants for the screen memory arbiter.
package screen_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned DEPTH_DEF  = 4800;
   localparam logic [15:0] CLEAR_VAL_DEF = 16'h0000;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VGA  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_e;

   // Return-routing tag carried one cycle behind each RAM issue
   typedef struct packed {
      owner_e owner;
      logic   oor;
   } tag_t;

endpackage

// File: rtl/screen_clear_engine.sv
// Clear sequencer: walks the screen address range writing one word per free slot.
module screen_clear_engine
   import screen_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_start,
   input  logic              slot_free,
   output logic              wr_fire,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              clear_busy,
   output logic              clear_done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // A write only fires in slots not taken by a VGA fetch
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      wr_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (slot_free) begin
               wr_fire = 1'b1;
               if (cnt_q == LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_addr    = cnt_q;
   assign clear_busy = (state_q == CLEAR);
   assign clear_done = done_q;

endmodule

// File: rtl/screen_mem_arbiter.sv
// Single-port screen RAM arbiter: VGA fetch > clear engine > CPU, with
// fixed two-cycle read returns routed by a registered owner tag.
module screen_mem_arbiter
   import screen_arb_pkg::*;
#(
   parameter int unsigned      ADDR_W    = ADDR_W_DEF,
   parameter int unsigned      DATA_W    = DATA_W_DEF,
   parameter int unsigned      DEPTH     = DEPTH_DEF,
   parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(CLEAR_VAL_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [DATA_W-1:0] vga_data,
   output logic              vga_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              cpu_err,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   logic              vga_in, cpu_in, cpu_acc;
   logic              clr_fire;
   logic [ADDR_W-1:0] clr_addr;
   tag_t              tag_d, tag_q;

   assign vga_in = (vga_addr < DEPTH_A);
   assign cpu_in = (cpu_addr < DEPTH_A);

   screen_clear_engine #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear (
      .clk         (clk),
      .reset       (reset),
      .clear_start (clear_start),
      .slot_free   (!vga_req),
      .wr_fire     (clr_fire),
      .wr_addr     (clr_addr),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done)
   );

   // Grant mux: out-of-range requests take their slot but never touch the RAM
   always_comb begin
      cpu_acc   = cpu_req & ~vga_req & ~clear_busy;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      tag_d     = '{owner: OWN_NONE, oor: 1'b0};
      if (vga_req) begin
         ram_en   = vga_in;
         ram_addr = vga_addr;
         tag_d    = '{owner: OWN_VGA, oor: ~vga_in};
      end else if (clr_fire) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = clr_addr;
         ram_wdata = CLEAR_VAL;
      end else if (cpu_acc) begin
         ram_en    = cpu_in;
         ram_we    = cpu_we & cpu_in;
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         if (!cpu_we) tag_d = '{owner: OWN_CPU, oor: ~cpu_in};
      end
   end

   assign cpu_ready = cpu_acc;
   assign cpu_err   = cpu_acc & ~cpu_in;

   // Tag stage aligns with ram_rdata; the return stage registers it to the owner
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_q      <= '{owner: OWN_NONE, oor: 1'b0};
         vga_data   <= '0;
         vga_valid  <= 1'b0;
         cpu_rdata  <= '0;
         cpu_rvalid <= 1'b0;
      end else begin
         tag_q      <= tag_d;
         vga_valid  <= (tag_q.owner == OWN_VGA);
         cpu_rvalid <= (tag_q.owner == OWN_CPU);
         if (tag_q.owner == OWN_VGA) vga_data  <= tag_q.oor ? '0 : ram_rdata;
         if (tag_q.owner == OWN_CPU) cpu_rdata <= tag_q.oor ? '0 : ram_rdata;
      end
   end

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Scoreboard bench for screen_mem_arbiter with a behavioural synchronous-read RAM.
module tb_screen_mem_arbiter;

   localparam int unsigned AW    = 16;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 4800;

   logic          clk = 1'b0;
   logic          reset;
   logic          vga_req;
   logic [AW-1:0] vga_addr;
   logic [DW-1:0] vga_data;
   logic          vga_valid;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ready;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_rvalid, cpu_err;
   logic          clear_start, clear_busy, clear_done;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   typedef struct {
      logic [DW-1:0] data;
      int unsigned   cyc;
   } exp_t;

   exp_t          vga_q[$];
   exp_t          cpu_q[$];
   logic [DW-1:0] mem    [65536];
   logic [DW-1:0] shadow [65536];
   int unsigned   cyc = 0;
   int unsigned   done_cnt = 0;
   int unsigned   ram_oob = 0;
   int unsigned   vectors = 0;
   int unsigned   miscompares = 0;
   logic          mem_init = 1'b1;

   screen_mem_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .vga_req     (vga_req),
      .vga_addr    (vga_addr),
      .vga_data    (vga_data),
      .vga_valid   (vga_valid),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ready   (cpu_ready),
      .cpu_rdata   (cpu_rdata),
      .cpu_rvalid  (cpu_rvalid),
      .cpu_err     (cpu_err),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
      .ram_en      (ram_en),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (clear_done) done_cnt <= done_cnt + 1;

   // Synchronous-read RAM; preloaded with a pattern on the first edge
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7 + 16'h1234);
      end else if (ram_en) begin
         if (ram_addr >= AW'(DEPTH)) ram_oob <= ram_oob + 1;
         else if (ram_we) mem[ram_addr] = ram_wdata;
         else ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop and compare every return the DUT presents
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (vga_valid) begin
            if (vga_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL vga_unexpected: got return %0h, expected none (cycle %0d)", vga_data, cyc);
            end else begin
               e = vga_q.pop_front();
               chk("vga_data", 32'(vga_data), 32'(e.data));
               chk("vga_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
         if (cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL cpu_unexpected: got return %0h, expected none (cycle %0d)", cpu_rdata, cyc);
            end else begin
               e = cpu_q.pop_front();
               chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
               chk("cpu_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic vga_read(input logic [AW-1:0] addr);
      vga_req  = 1'b1;
      vga_addr = addr;
      vga_q.push_back('{data: (addr < AW'(DEPTH)) ? shadow[addr] : '0, cyc: cyc + 2});
      tick();
      vga_req = 1'b0;
   endtask

   task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      int unsigned waited;
      logic        in_rng;
      waited    = 0;
      in_rng    = (addr < AW'(DEPTH));
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      #3;
      while (!cpu_ready && waited < 8) begin
         tick(); #3; waited++;
      end
      chk("cpu_accept", 32'(cpu_ready), 32'(1));
      chk("cpu_err", 32'(cpu_err), 32'(!in_rng));
      if (!in_rng) chk("oor_ram_en", 32'(ram_en), 32'(0));
      if (!we) cpu_q.push_back('{data: in_rng ? shadow[addr] : '0, cyc: cyc + 2});
      else if (in_rng) shadow[addr] = wdata;
      tick();
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
   endtask

   initial begin
      int unsigned n, stolen, bad, nz, d0;
      reset = 1'b1; vga_req = 1'b0; vga_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; clear_start = 1'b0;
      for (int i = 0; i < 65536; i++) shadow[i] = 16'(i * 7 + 16'h1234);
      tick();
      mem_init = 1'b0;
      repeat (2) tick();
      chk("reset_ctrl", 32'({vga_valid, cpu_rvalid, cpu_err, clear_busy, clear_done,
                             ram_en, ram_we, cpu_ready}), 32'(0));
      chk("reset_data", {vga_data, cpu_rdata}, 32'(0));
      reset = 1'b0;
      tick();

      // Basic write / read / VGA fetch
      cpu_op(1'b1, 16'd5, 16'hA5A5);
      cpu_op(1'b0, 16'd5, 16'h0000);
      vga_read(16'd5);
      repeat (3) tick();

      // VGA and CPU collide: VGA first, CPU one cycle later
      vga_req = 1'b1; vga_addr = 16'd7;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd9;
      vga_q.push_back('{data: shadow[7], cyc: cyc + 2});
      #3 chk("collide_ready0", 32'(cpu_ready), 32'(0));
      tick();
      vga_req = 1'b0;
      #3 chk("collide_ready1", 32'(cpu_ready), 32'(1));
      cpu_q.push_back('{data: shadow[9], cyc: cyc + 2});
      tick();
      cpu_req = 1'b0;
      repeat (3) tick();

      // Out-of-range accesses
      cpu_op(1'b1, 16'd4800, 16'hBEEF);
      cpu_op(1'b0, 16'hFFFF, 16'h0000);
      vga_read(16'd5000);
      repeat (3) tick();

      // Clear with a VGA fetch stealing every 10th slot, CPU held off
      d0 = done_cnt;
      clear_start = 1'b1; tick(); clear_start = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd3;
      n = 0; stolen = 0; bad = 0;
      while (clear_busy && n < 20000) begin
         vga_req = (n % 10 == 5);
         if (vga_req) begin
            vga_addr = (stolen % 2 == 0) ? 16'd4799 : 16'hFFFF;
            vga_q.push_back('{data: (stolen % 2 == 0) ? shadow[4799] : '0, cyc: cyc + 2});
            stolen++;
         end
         #3 if (cpu_ready) bad++;
         tick();
         n++;
      end
      vga_req = 1'b0; cpu_req = 1'b0;
      chk("clear_done_first_idle", 32'(clear_done), 32'(1));
      chk("clear_len_stolen", 32'(n), 32'(DEPTH + stolen));
      chk("cpu_ready_in_clear", 32'(bad), 32'(0));
      repeat (3) tick();
      chk("clear_done_once", 32'(done_cnt - d0), 32'(1));
      nz = 0;
      for (int i = 0; i < int'(DEPTH); i++) if (mem[i] != '0) nz++;
      chk("clear_all_zero", 32'(nz), 32'(0));
      for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;

      // Reset mid-clear at count 2000
      cpu_op(1'b1, 16'd1999, 16'h1111);
      cpu_op(1'b1, 16'd2000, 16'h2222);
      vga_read(16'd1999);
      cpu_op(1'b0, 16'd2000, 16'h0000);
      repeat (3) tick();
      clear_start = 1'b1; tick(); clear_start = 1'b0;
      repeat (2000) tick();
      reset = 1'b1;
      #1;
      chk("midreset_ctrl", 32'({vga_valid, cpu_rvalid, cpu_err, clear_busy, clear_done,
                                ram_en, ram_we, cpu_ready}), 32'(0));
      chk("midreset_data", {vga_data, cpu_rdata}, 32'(0));
      tick();
      reset = 1'b0;
      tick();
      chk("partial_1999", 32'(mem[1999]), 32'(0));
      chk("partial_2000", 32'(mem[2000]), 32'(16'h2222));

      // Restart completes in exactly DEPTH cycles without VGA traffic
      d0 = done_cnt;
      clear_start = 1'b1; tick(); clear_start = 1'b0;
      n = 0;
      while (clear_busy && n < 20000) begin
         tick(); n++;
      end
      chk("restart_len", 32'(n), 32'(DEPTH));
      repeat (3) tick();
      chk("restart_done_once", 32'(done_cnt - d0), 32'(1));
      nz = 0;
      for (int i = 0; i < int'(DEPTH); i++) if (mem[i] != '0) nz++;
      chk("restart_all_zero", 32'(nz), 32'(0));

      // Back-to-back reads, then clear with an ignored second start
      for (int i = 0; i < 20; i++) cpu_op(1'b1, AW'(100 + i), DW'(16'h5000 + i));
      for (int i = 0; i < 20; i++) begin
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(100 + i);
         #3 chk("b2b_ready", 32'(cpu_ready), 32'(1));
         cpu_q.push_back('{data: shadow[100 + i], cyc: cyc + 2});
         tick();
      end
      cpu_req = 1'b0;
      d0 = done_cnt;
      clear_start = 1'b1; tick(); clear_start = 1'b0;
      n = 0;
      while (clear_busy && n < 20000) begin
         clear_start = (n == 100);
         tick(); n++;
      end
      clear_start = 1'b0;
      chk("ignored_restart_len", 32'(n), 32'(DEPTH));
      repeat (3) tick();
      chk("ignored_done_once", 32'(done_cnt - d0), 32'(1));

      repeat (5) tick();
      chk("vga_q_drained", 32'(vga_q.size()), 32'(0));
      chk("cpu_q_drained", 32'(cpu_q.size()), 32'(0));
      chk("ram_oob_access", 32'(ram_oob), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
